// File: rtl/time_display_driver_pkg.sv
// Shared definitions for the time display driver: digit count and scan-slot indices,
// converter FSM states, the 7-segment font and the packing order of the committed BCD
// word.
package time_display_driver_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Scan slot order, rightmost digit first
  localparam logic [2:0] IDX_S1  = 3'd0;
  localparam logic [2:0] IDX_S10 = 3'd1;
  localparam logic [2:0] IDX_M1  = 3'd2;
  localparam logic [2:0] IDX_M10 = 3'd3;
  localparam logic [2:0] IDX_H1  = 3'd4;
  localparam logic [2:0] IDX_H10 = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StCommit
  } state_e;

  // Active-high segment patterns, bits g..a, entry 9 first
  localparam logic [9:0][6:0] SEG_PATTERN = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Committed BCD word, {h10,h1,m10,m1,s10,s1}
  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
  } bcd_time_t;

  // Non-decimal nibbles render as a dark digit
  function automatic logic [6:0] seg_decode(logic [3:0] nib);
    return (nib > 4'd9) ? 7'b0000000 : SEG_PATTERN[nib];
  endfunction

endpackage

// File: rtl/time_display_driver_if.sv
// Bundle between the time counter / board pins and the display driver.
//   master: the display driver (reads time fields, blink and blank; drives pins/digits)
//   slave:  the surrounding environment
//   seconds/minutes/hours : binary time fields (6 bits each)
//   Clk_1sec              : 1 Hz colon blink level
//   blank                 : force display dark
//   seg/dp/an             : display pins
//   digits/bcd_valid      : committed BCD word and its valid flag
interface time_display_driver_if;
  logic [5:0]                                       seconds;
  logic [5:0]                                       minutes;
  logic [5:0]                                       hours;
  logic                                             Clk_1sec;
  logic                                             blank;
  logic [6:0]                                       seg;
  logic                                             dp;
  logic [time_display_driver_pkg::NUM_DIGITS-1:0]   an;
  logic [23:0]                                      digits;
  logic                                             bcd_valid;

  modport master (
    input  seconds, minutes, hours, Clk_1sec, blank,
    output seg, dp, an, digits, bcd_valid
  );

  modport slave (
    output seconds, minutes, hours, Clk_1sec, blank,
    input  seg, dp, an, digits, bcd_valid
  );
endinterface

// File: rtl/time_display_driver_bin6_to_bcd_seq.sv
// Serial double-dabble: 6-bit binary to two BCD digits in six clocks.
//   clk, reset : clock and synchronous active-high reset
//   start      : load bin and begin a conversion (restarts one in flight)
//   bin        : binary value 0..63
//   bcd        : {tens, ones} result, valid while done is high
//   done       : no conversion in flight
module bin6_to_bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  logic [5:0] bin_q;
  logic [7:0] bcd_q;
  logic [2:0] cnt_q;
  logic [7:0] adj;

  // Add 3 to any nibble >= 5 before it is doubled by the shift
  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= 3'd6;
    end else if (cnt_q != 3'd0) begin
      {bcd_q, bin_q} <= {adj, bin_q} << 1;
      cnt_q          <= cnt_q - 3'd1;
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == 3'd0);

endmodule

// File: rtl/time_display_driver.sv
// Snapshots seconds/minutes/hours once per refresh frame, converts them to BCD and
// scans the six digits onto a common-anode 7-segment display with a blinking colon.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : time inputs, blink/blank controls, display pins and BCD word
module time_display_driver
  import time_display_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,  // clocks per digit slot, >= 9
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  time_display_driver_if.master bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  state_e               state_q;
  logic [DivW-1:0]      div_q;
  logic [2:0]           idx_q;
  logic [2:0]           shift_cnt_q;
  logic                 first_q;     // one conversion is owed right after reset
  bcd_time_t            digits_q;
  logic                 bcd_valid_q;
  logic [6:0]           seg_q;
  logic                 dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                 div_tc;
  logic                 frame_wrap;
  logic                 conv_start;
  logic [7:0]           bcd_s, bcd_m, bcd_h;
  logic                 done_s, done_m, done_h;

  assign div_tc     = (div_q == DivW'(SCAN_DIV - 1));
  assign frame_wrap = div_tc && (idx_q == IDX_H10);
  assign conv_start = (state_q == StLoad);

  bin6_to_bcd_seq u_conv_s (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (bus.seconds),
    .bcd   (bcd_s),
    .done  (done_s)
  );

  bin6_to_bcd_seq u_conv_m (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (bus.minutes),
    .bcd   (bcd_m),
    .done  (done_m)
  );

  bin6_to_bcd_seq u_conv_h (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (bus.hours),
    .bcd   (bcd_h),
    .done  (done_h)
  );

  // Scan divider, digit index and conversion sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      idx_q       <= '0;
      shift_cnt_q <= '0;
      first_q     <= 1'b1;
      digits_q    <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      div_q <= div_tc ? '0 : div_q + DivW'(1);
      if (div_tc) idx_q <= (idx_q == IDX_H10) ? IDX_S1 : idx_q + 3'd1;

      unique case (state_q)
        StIdle: begin
          if (first_q || frame_wrap) begin
            state_q <= StLoad;
            first_q <= 1'b0;
          end
        end
        StLoad: begin
          state_q     <= StShift;
          shift_cnt_q <= '0;
        end
        StShift: begin
          if (shift_cnt_q == 3'd5) state_q <= StCommit;
          else                     shift_cnt_q <= shift_cnt_q + 3'd1;
        end
        StCommit: begin
          if (done_s && done_m && done_h) begin
            digits_q    <= '{hours: bcd_h, minutes: bcd_m, seconds: bcd_s};
            bcd_valid_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [23:0]           digits_flat;
  logic [3:0]            nib;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] an_on;
  logic                  dp_on;

  // Active-high view of the current slot; polarity is applied at the register
  always_comb begin
    digits_flat = digits_q;
    nib         = digits_flat[{idx_q, 2'b00} +: 4];
    seg_on      = '0;
    an_on       = '0;
    dp_on       = 1'b0;
    if (!bus.blank) begin
      seg_on       = seg_decode(nib);
      an_on[idx_q] = 1'b1;
      dp_on        = bus.Clk_1sec && ((idx_q == IDX_M1) || (idx_q == IDX_H1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= {7{SEG_ACTIVE_LOW}};
      an_q  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      dp_q  <= SEG_ACTIVE_LOW;
    end else begin
      seg_q <= seg_on ^ {7{SEG_ACTIVE_LOW}};
      an_q  <= an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      dp_q  <= dp_on ^ SEG_ACTIVE_LOW;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;
  assign bus.digits    = digits_q;
  assign bus.bcd_valid = bcd_valid_q;

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
Reader end of the time counter's seconds/minutes/hours outputs. Once per refresh frame it snapshots the three 6-bit binary fields and converts each to two BCD digits with a serial double-dabble. It then time-multiplexes the six digits onto a common-anode 7-segment display with a blinking colon. It sits between the clock/stopwatch counter and the board display pins.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays enabled; must be >= 9 so conversion finishes within one digit slot.
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light.
AN_ACTIVE_LOW, 1, 1 = an driven low to enable a digit.

Ports:
clk  in  1  fast system clock.
reset  in  1  synchronous, active-high reset.
seconds  in  6  binary seconds, nominal 0..59.
minutes  in  6  binary minutes, nominal 0..59.
hours  in  6  binary hours, nominal 0..23.
Clk_1sec  in  1  1 Hz square wave, level-sampled for colon blink.
blank  in  1  1 = display dark, scan keeps running.
seg  out  7  segments, bit0=a .. bit6=g.
dp  out  1  decimal point, used as colon.
an  out  6  digit enables, one-hot when active.
digits  out  24  committed BCD {h10,h1,m10,m1,s10,s1}, 4 bits each.
bcd_valid  out  1  high after the first conversion commits.

Behaviour:
- Reset: one clock, synchronous, active-high. All of an = inactive, seg = all off, dp = off (polarity per parameters); digits=0, bcd_valid=0, FSM=IDLE, digit index=0, divider=0.
- Reset mid-conversion aborts the conversion; the reset values above apply on the next edge.
- FSM IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE.
  - IDLE -> LOAD on the first cycle after reset deasserts, and at every frame boundary (index wraps 5->0).
  - LOAD (1 cycle): register all three inputs. Inputs are ignored outside LOAD.
  - SHIFT (exactly 6 cycles): three converters run in lockstep. Each applies add-3 to any nibble >=5, then shifts.
  - COMMIT (1 cycle): digits and bcd_valid=1 update on the edge leaving COMMIT.
  - Latency: 8 clks from LOAD entry to new digits. The display keeps showing old digits until then.
- No clamping. Inputs up to 63 convert literally (63 -> "63"). Tens nibble max is 6; nibble values 10..15 decode to blank.
- Scan divider counts 0..SCAN_DIV-1. At the terminal count, index advances 0..5 and wraps.
- Digit mapping: index 0=s1, 1=s10, 2=m1, 3=m10, 4=h1, 5=h10. an[index] is active; seg shows the decoded nibble.
- Seg outputs are registered: seg, an and dp change together, one cycle after the index changes.
- No leading-zero suppression.
- dp is lit only when index is 2 or 4 and Clk_1sec=1.
- blank=1: an all inactive, seg/dp off. Divider, index and FSM keep running. Deasserting blank resumes at the current index.
- Decode table (active-high, g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Inverted when SEG_ACTIVE_LOW=1.

Decomposition:
- Shared package holds:
  - NUM_DIGITS=6 and the digit index constants.
  - FSM state enum {IDLE, LOAD, SHIFT, COMMIT}.
  - The 10-entry segment pattern constant.
  - The BCD field packing order.
- One sub-module, bin6_to_bcd_seq: serial 6-bit double-dabble with start/done, instantiated three times.

Test Plan:
- Reset, then inputs 12:34:56, SCAN_DIV=9 -> 8 clks after reset release digits=24'h123456 and bcd_valid=1; index-0 slot gives an=6'b111110 and seg=7'b0000010 ('6').
- Load 23:59:59, then change inputs to 00:00:00 during SHIFT -> digits stay 24'h235959 until the next frame's COMMIT, then become 24'h000000.
- seconds=63, minutes=60, hours=31 -> digits=24'h316063; no clamp or blank.
- Clk_1sec=1 -> dp active only while an[2] or an[4] is enabled; Clk_1sec=0 -> dp never active.
- blank=1 during index 3 -> an=6'b111111 and seg=7'b1111111; release after 2 slots -> display resumes at index 5 with correct data.
- Assert reset for 1 clk during SHIFT -> next edge: an/seg off, digits=0, bcd_valid=0; a fresh conversion completes 8 clks after release.
